// File: rtl/ins_cache_ml.sv
// Direct-mapped instruction cache with whole-line DDR refill and an uncached path for the upper half of the address space.
// Optional hit/miss statistics counters are built when INS_CACHE_STATS_EN is defined.
module ins_cache_ml #(
    parameter int unsigned ISA_WIDTH      = 30,
    parameter int unsigned ADDR_WIDTH_MEM = 16,
    parameter int unsigned DDR_ADDR_WIDTH = 28,
    parameter int unsigned LINE_WORDS     = 16,
    parameter int unsigned NUM_LINES      = 8,
    parameter int unsigned DDR_STRIDE     = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      fetch_req,
    input  logic [ADDR_WIDTH_MEM-1:0] fetch_addr,
    output logic                      fetch_rdy,
    output logic                      ins_valid,
    output logic [ISA_WIDTH-1:0]      instruction,
    input  logic                      flush,
    output logic                      ISA_read_req,
    output logic [DDR_ADDR_WIDTH-1:0] ISA_read_addr,
    output logic [9:0]                isa_read_len,
    input  logic [ISA_WIDTH-1:0]      instruction_to_cache,
    input  logic [9:0]                rd_cnt_isa,
    input  logic                      rd_burst_data_valid
`ifdef INS_CACHE_STATS_EN
    ,
    output logic [31:0]               hit_cnt,
    output logic [31:0]               miss_cnt
`endif
);

    localparam int unsigned OFF_W    = $clog2(LINE_WORDS);
    localparam int unsigned IDX_W    = $clog2(NUM_LINES);
    localparam int unsigned LINE_W   = (IDX_W > 0) ? IDX_W : 1;
    localparam int unsigned MEM_W    = OFF_W + IDX_W;
    localparam int unsigned TAG_W    = ADDR_WIDTH_MEM - MEM_W;
    localparam int unsigned STRIDE_W = $clog2(DDR_STRIDE);
    localparam int unsigned DEPTH    = NUM_LINES * LINE_WORDS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_REFILL,
        S_UNCACHED,
        S_RESPOND,
        S_FLUSH
    } state_t;

    state_t                    state;
    logic [ADDR_WIDTH_MEM-1:0] req_addr;
    logic                      beat_done;
    logic                      flush_pend;
    logic [NUM_LINES-1:0]      line_valid;
    logic [TAG_W-1:0]          line_tag [NUM_LINES];
    logic [ISA_WIDTH-1:0]      line_mem [DEPTH];

    // Address decode of the latched request; word select doubles as the storage address.
    logic [MEM_W-1:0]          word_sel_c;
    logic [LINE_W-1:0]         line_sel_c;
    logic [TAG_W-1:0]          tag_c;
    logic                      uncached_c;
    logic                      hit_c;
    logic [ADDR_WIDTH_MEM-1:0] line_base_c;
    logic                      beat_ok_c;
    logic                      fill_we_c;
    logic                      fill_last_c;
    logic [MEM_W-1:0]          fill_addr_c;

    assign word_sel_c  = req_addr[MEM_W-1:0];
    assign line_sel_c  = LINE_W'(word_sel_c >> OFF_W);
    assign tag_c       = req_addr[ADDR_WIDTH_MEM-1:MEM_W];
    assign uncached_c  = req_addr[ADDR_WIDTH_MEM-1];
    assign hit_c       = line_valid[line_sel_c] && (line_tag[line_sel_c] == tag_c);
    assign line_base_c = req_addr & ~ADDR_WIDTH_MEM'(LINE_WORDS - 1);
    assign beat_ok_c   = rd_burst_data_valid && (rd_cnt_isa != 10'd0)
                         && (rd_cnt_isa <= 10'(LINE_WORDS));
    assign fill_we_c   = !rst && (state == S_REFILL) && !beat_done && beat_ok_c;
    assign fill_last_c = (rd_cnt_isa == 10'(LINE_WORDS));
    assign fill_addr_c = (word_sel_c & ~MEM_W'(LINE_WORDS - 1))
                         | (MEM_W'(rd_cnt_isa - 10'd1) & MEM_W'(LINE_WORDS - 1));

    // Line storage: written only by refill beats.
    always_ff @(posedge clk) begin
        if (fill_we_c) begin
            line_mem[fill_addr_c] <= instruction_to_cache;
        end
    end

    // Control FSM; a refill or uncached beat takes one extra cycle to settle before responding.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            req_addr      <= '0;
            beat_done     <= 1'b0;
            flush_pend    <= 1'b0;
            line_valid    <= '0;
            fetch_rdy     <= 1'b0;
            ins_valid     <= 1'b0;
            instruction   <= '0;
            ISA_read_req  <= 1'b0;
            ISA_read_addr <= '0;
            isa_read_len  <= '0;
`ifdef INS_CACHE_STATS_EN
            hit_cnt       <= '0;
            miss_cnt      <= '0;
`endif
        end else begin
            if (state != S_IDLE && flush) begin
                flush_pend <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (flush || flush_pend) begin
                        flush_pend <= 1'b0;
                        fetch_rdy  <= 1'b0;
                        state      <= S_FLUSH;
                    end else if (fetch_req && fetch_rdy) begin
                        req_addr  <= fetch_addr;
                        fetch_rdy <= 1'b0;
                        state     <= S_LOOKUP;
                    end else begin
                        fetch_rdy <= 1'b1;
                    end
                end
                S_LOOKUP: begin
                    if (uncached_c) begin
                        ISA_read_req  <= 1'b1;
                        ISA_read_addr <= DDR_ADDR_WIDTH'(req_addr) << STRIDE_W;
                        isa_read_len  <= 10'd1;
                        state         <= S_UNCACHED;
                    end else if (hit_c) begin
                        instruction <= line_mem[word_sel_c];
                        ins_valid   <= 1'b1;
                        state       <= S_RESPOND;
                    end else begin
                        line_valid[line_sel_c] <= 1'b0;
                        ISA_read_req  <= 1'b1;
                        ISA_read_addr <= DDR_ADDR_WIDTH'(line_base_c) << STRIDE_W;
                        isa_read_len  <= 10'(LINE_WORDS);
                        state         <= S_REFILL;
                    end
`ifdef INS_CACHE_STATS_EN
                    if (!uncached_c && hit_c) begin
                        if (hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
                    end else begin
                        if (miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
                    end
`endif
                end
                S_REFILL: begin
                    if (beat_done) begin
                        line_tag[line_sel_c]   <= tag_c;
                        line_valid[line_sel_c] <= 1'b1;
                        instruction <= line_mem[word_sel_c];
                        ins_valid   <= 1'b1;
                        beat_done   <= 1'b0;
                        state       <= S_RESPOND;
                    end else if (fill_we_c && fill_last_c) begin
                        ISA_read_req <= 1'b0;
                        beat_done    <= 1'b1;
                    end
                end
                S_UNCACHED: begin
                    if (beat_done) begin
                        ins_valid <= 1'b1;
                        beat_done <= 1'b0;
                        state     <= S_RESPOND;
                    end else if (rd_burst_data_valid) begin
                        instruction  <= instruction_to_cache;
                        ISA_read_req <= 1'b0;
                        beat_done    <= 1'b1;
                    end
                end
                S_RESPOND: begin
                    ins_valid <= 1'b0;
                    fetch_rdy <= !(flush_pend || flush);
                    state     <= S_IDLE;
                end
                S_FLUSH: begin
                    line_valid <= '0;
                    flush_pend <= flush;
                    fetch_rdy  <= !flush;
                    state      <= S_IDLE;
`ifdef INS_CACHE_STATS_EN
                    hit_cnt    <= '0;
                    miss_cnt   <= '0;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ins_cache_ml.sv
// Directed bench for ins_cache_ml: a DDR responder driven inline, expected instructions queued at acceptance.
// Stats checks are compiled in when INS_CACHE_STATS_EN is defined.
module tb_ins_cache_ml;

    localparam int K_HIT  = 0;
    localparam int K_MISS = 1;
    localparam int K_UNC  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic        fetch_rdy;
    logic        ins_valid;
    logic [29:0] instruction;
    logic        flush;
    logic        ISA_read_req;
    logic [27:0] ISA_read_addr;
    logic [9:0]  isa_read_len;
    logic [29:0] instruction_to_cache;
    logic [9:0]  rd_cnt_isa;
    logic        rd_burst_data_valid;
`ifdef INS_CACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    ins_cache_ml dut (
        .clk                  (clk),
        .rst                  (rst),
        .fetch_req            (fetch_req),
        .fetch_addr           (fetch_addr),
        .fetch_rdy            (fetch_rdy),
        .ins_valid            (ins_valid),
        .instruction          (instruction),
        .flush                (flush),
        .ISA_read_req         (ISA_read_req),
        .ISA_read_addr        (ISA_read_addr),
        .isa_read_len         (isa_read_len),
        .instruction_to_cache (instruction_to_cache),
        .rd_cnt_isa           (rd_cnt_isa),
        .rd_burst_data_valid  (rd_burst_data_valid)
`ifdef INS_CACHE_STATS_EN
        ,
        .hit_cnt              (hit_cnt),
        .miss_cnt             (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [29:0] exp_q[$];
    logic [29:0] obs_q[$];
    int          obs_cyc_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          last_acc = 0;

    // Capture every response with the cycle it appeared in.
    always @(negedge clk) begin
        if (ins_valid) begin
            obs_q.push_back(instruction);
            obs_cyc_q.push_back(cyc);
        end
    end

    // DDR content: every instruction address holds a distinct word.
    function automatic logic [29:0] ddr_word(input logic [15:0] a);
        return {a[7:0] ^ 8'h5A, 6'h2B, a};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_resp(input string tag, input int t_resp);
        int g;
        logic [29:0] e;
        g = 0;
        while (obs_q.size() == 0 && g < 200) begin
            @(negedge clk);
            #1;
            g++;
        end
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else e = '0;
        if (obs_q.size() == 0) begin
            check({tag, "_timeout"}, 64'd0, 64'd1);
        end else begin
            check({tag, "_data"}, 64'(obs_q.pop_front()), 64'(e));
            check({tag, "_lat"}, 64'(obs_cyc_q.pop_front()), 64'(t_resp));
        end
    endtask

    task automatic fetch(input string tag, input logic [15:0] a, input int kind,
                         input int flush_at, input int rst_at);
        int g, t_acc, t_last, len;
        logic [15:0] w0;
        logic [27:0] ea;
        g = 0;
        @(negedge clk);
        while (!fetch_rdy && g < 50) begin
            @(negedge clk);
            g++;
        end
        check({tag, "_rdy"}, 64'(fetch_rdy), 64'd1);
        fetch_req  = 1'b1;
        fetch_addr = a;
        t_acc      = cyc;
        last_acc   = t_acc;
        exp_q.push_back(ddr_word(a));
        @(negedge clk);
        fetch_req = 1'b0;
        if (kind == K_HIT) begin
            wait_resp(tag, t_acc + 2);
            check({tag, "_noreq"}, 64'(ISA_read_req), 64'd0);
            return;
        end
        @(negedge clk);
        len = (kind == K_MISS) ? 16 : 1;
        w0  = (kind == K_MISS) ? (a & 16'hFFF0) : a;
        ea  = 28'(w0) << 3;
        check({tag, "_req"}, 64'(ISA_read_req), 64'd1);
        check({tag, "_addr"}, 64'(ISA_read_addr), 64'(ea));
        check({tag, "_len"}, 64'(isa_read_len), 64'(len));
        t_last = t_acc;
        for (int i = 1; i <= len; i++) begin
            rd_burst_data_valid  = 1'b1;
            rd_cnt_isa           = 10'(i);
            instruction_to_cache = (rst_at != 0 && i > rst_at) ? ~ddr_word(w0 + 16'(i - 1))
                                                               : ddr_word(w0 + 16'(i - 1));
            flush  = (i == flush_at);
            rst    = (i == rst_at);
            t_last = cyc;
            if (i == len && rst_at == 0) begin
                check({tag, "_addr_hold"}, 64'(ISA_read_addr), 64'(ea));
            end
            @(negedge clk);
            if (i == rst_at) begin
                check({tag, "_req_after_rst"}, 64'(ISA_read_req), 64'd0);
            end
        end
        rd_burst_data_valid = 1'b0;
        flush = 1'b0;
        rst   = 1'b0;
        if (rst_at != 0) begin
            void'(exp_q.pop_back());
            repeat (5) @(negedge clk);
            check({tag, "_noresp"}, 64'(obs_q.size()), 64'd0);
            return;
        end
        check({tag, "_reqdrop"}, 64'(ISA_read_req), 64'd0);
        wait_resp(tag, t_last + 2);
    endtask

    initial begin
        int first;
        rst = 1'b1;
        fetch_req = 1'b0;
        fetch_addr = '0;
        flush = 1'b0;
        instruction_to_cache = '0;
        rd_cnt_isa = '0;
        rd_burst_data_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rdy", 64'(fetch_rdy), 64'd0);
        check("rst_valid", 64'(ins_valid), 64'd0);
        check("rst_instr", 64'(instruction), 64'd0);
        check("rst_req", 64'(ISA_read_req), 64'd0);
        check("rst_addr", 64'(ISA_read_addr), 64'd0);
        check("rst_len", 64'(isa_read_len), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rdy_after_rst", 64'(fetch_rdy), 64'd1);

        fetch("cold_0005", 16'h0005, K_MISS, 0, 0);
`ifdef INS_CACHE_STATS_EN
        check("miss_cnt_1", 64'(miss_cnt), 64'd1);
`endif
        fetch("hit_000f", 16'h000F, K_HIT, 0, 0);
        first = last_acc;
        fetch("hit_0003", 16'h0003, K_HIT, 0, 0);
        check("b2b_spacing", 64'(last_acc - first), 64'd3);
`ifdef INS_CACHE_STATS_EN
        check("hit_cnt_2", 64'(hit_cnt), 64'd2);
`endif
        fetch("conflict_0083", 16'h0083, K_MISS, 0, 0);
        fetch("evicted_0003", 16'h0003, K_MISS, 0, 0);

        fetch("unc_8010", 16'h8010, K_UNC, 0, 0);
        fetch("after_unc_0010", 16'h0010, K_MISS, 0, 0);
        fetch("hit_0010", 16'h0010, K_HIT, 0, 0);

        fetch("flush_mid_0021", 16'h0021, K_MISS, 5, 0);
        fetch("reflush_0021", 16'h0021, K_MISS, 0, 0);
        fetch("reflush_0010", 16'h0010, K_MISS, 0, 0);

        // Flush and request together: flush wins, request dropped.
        @(negedge clk);
        fetch_req  = 1'b1;
        fetch_addr = 16'h0010;
        flush      = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0;
        flush     = 1'b0;
        check("coflush_rdy", 64'(fetch_rdy), 64'd0);
        repeat (4) @(negedge clk);
        check("coflush_noresp", 64'(obs_q.size()), 64'd0);
        check("coflush_noreq", 64'(ISA_read_req), 64'd0);
        check("instr_hold", 64'(instruction), 64'(ddr_word(16'h0010)));
        fetch("coflush_0010", 16'h0010, K_MISS, 0, 0);

        fetch("rst_mid_0045", 16'h0045, K_MISS, 0, 7);
        fetch("refill_0045", 16'h0045, K_MISS, 0, 0);
        fetch("hit_004a", 16'h004A, K_HIT, 0, 0);
        fetch("post_rst_0010", 16'h0010, K_MISS, 0, 0);

        repeat (3) @(negedge clk);
        check("no_stray_resp", 64'(obs_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
